// File: rtl/fsqrt_table_loader_if.sv
// Byte stream from the host receiver plus the coefficient RAM write port.
interface fsqrt_table_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 36
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // master: the loader; slave: host byte source and RAM write port
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/fsqrt_table_loader.sv
// Fills the fsqrt coefficient table from a little-endian byte stream,
// five bytes per entry, followed by an XOR checksum byte.
module fsqrt_table_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 36
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  fsqrt_table_loader_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  ok,
  output logic                  fmt_err
);

  typedef enum logic [2:0] {S_IDLE, S_BYTE, S_WRITE, S_CSUM, S_DONE} state_t;

  localparam int unsigned       HI_W      = DATA_W - 32;
  // Bits of the fifth byte that fall outside the entry width
  localparam logic [7:0]        HI_MASK   = ~8'((16'h1 << HI_W) - 16'h1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              rx_ready_d, we_d;
  logic              busy_d, done_d, ok_d, fmt_err_d;
  logic              accept_c;

  assign accept_c = bus.rx_valid & bus.rx_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    buf_d      = buf_q;
    waddr_d    = bus.waddr;
    wdata_d    = bus.wdata;
    busy_d     = busy;
    done_d     = done;
    ok_d       = ok;
    fmt_err_d  = fmt_err;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_BYTE;
          addr_d     = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          ok_d       = 1'b0;
          fmt_err_d  = 1'b0;
        end
      end
      S_BYTE: begin
        if (accept_c) begin
          csum_d = csum_q ^ bus.rx_data;
          if (byte_cnt_q == 3'd4) begin
            // Truncating cast drops fifth-byte bits beyond DATA_W
            state_d = S_WRITE;
            waddr_d = addr_q;
            wdata_d = DATA_W'({bus.rx_data, buf_q});
            if ((bus.rx_data & HI_MASK) != 8'h00) fmt_err_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            buf_d      = {bus.rx_data, buf_q[31:8]};
          end
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_CSUM;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          byte_cnt_d = '0;
          state_d    = S_BYTE;
        end
      end
      S_CSUM: begin
        if (accept_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ok_d    = (bus.rx_data == csum_q) & ~fmt_err;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_BYTE) || (state_d == S_CSUM);
    we_d       = (state_d == S_WRITE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      csum_q       <= '0;
      buf_q        <= '0;
      bus.rx_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ok           <= 1'b0;
      fmt_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      buf_q        <= buf_d;
      bus.rx_ready <= rx_ready_d;
      bus.we       <= we_d;
      bus.waddr    <= waddr_d;
      bus.wdata    <= wdata_d;
      busy         <= busy_d;
      done         <= done_d;
      ok           <= ok_d;
      fmt_err      <= fmt_err_d;
    end
  end

endmodule

// File: doc/fsqrt_table_loader.md
Name: fsqrt_table_loader

Overview:
- Writer side of the fsqrt coefficient table: fills the 1024-entry x 36-bit block RAM that the fsqrt pipeline reads.
- Each entry holds a 23-bit constant term in bits [35:13] and a 13-bit gradient in bits [12:0].
- Entries arrive as a byte stream from the host link (UART receiver or boot ROM streamer) under a valid/ready handshake.
- Each completed entry is written through the RAM write port. A trailing checksum byte is verified.
- Sits between the host byte receiver and the RAM write port. It runs once at boot, before any fsqrt instruction issues.

Parameters:
- ADDR_W, 10, table address width; the table holds 2^ADDR_W entries. The address is {exp[0], mantissa[22:14]}.
- DATA_W, 36, entry width. Legal range is 33..40, so every entry is always 5 bytes.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- we  out  1  RAM write enable, one-cycle pulse.
- waddr  out  ADDR_W  RAM write address.
- wdata  out  DATA_W  RAM write data.
- busy  out  1  a load is in progress.
- done  out  1  load finished; level output.
- ok  out  1  checksum matched and no format error. Valid only while done=1.
- fmt_err  out  1  sticky flag: a 5th byte had nonzero bits above DATA_W-32.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE.
  - rx_ready, we, busy, done, ok, fmt_err = 0.
  - waddr=0, wdata=0.
  - Internal byte counter, address counter and checksum = 0.
  - Reset mid-load abandons it immediately. RAM contents are left partially written. No write is issued after rstn deasserts until a new start.
- States: IDLE, BYTE, WRITE, CSUM, DONE.
- IDLE / DONE + start:
  - Go to BYTE; address=0, byte_cnt=0, csum=0.
  - Clear done, ok and fmt_err; set busy=1.
  - start in any other state is ignored.
- BYTE:
  - rx_ready=1. A byte is accepted when rx_valid & rx_ready.
  - Bytes are little-endian: byte k (k=0..4) loads entry bits [8k+7:8k], truncated to DATA_W.
  - If any accepted byte-4 bit at position >= DATA_W-32 is 1: fmt_err <= 1. Those bits are dropped and the entry is still written.
  - Every accepted byte is XORed into csum, including all 5 bytes per entry.
  - On the 5th accepted byte: go to WRITE; wdata and waddr are registered that edge.
- WRITE:
  - we=1 for exactly one cycle; rx_ready=0.
  - Next edge: if address == 2^ADDR_W-1, go to CSUM. Otherwise address+1, byte_cnt=0, go to BYTE.
  - The address never wraps within a load.
- CSUM:
  - rx_ready=1. Accept one byte, then go to DONE with:
    - done <= 1, busy <= 0.
    - ok <= (byte == csum) & ~fmt_err.
- DONE:
  - done, ok and fmt_err hold until the next start or reset.
  - rx_ready=0; bytes offered here are not consumed.
- rx_ready depends only on state, never on rx_valid.
- Stalls of any length (rx_valid=0) are legal in BYTE and CSUM; no timeout.
- Maximum throughput: one entry per 6 cycles. A full load with back-to-back bytes takes 6*1024+1 cycles from the first accepted byte to done.
- we is never asserted outside WRITE.
- waddr and wdata stay stable from the WRITE cycle until the next WRITE.

Test Plan:
1. Reset, start, stream entry i = {23'(i*3), 13'(i)} for i=0..1023 with correct XOR checksum, rx_valid held high.
   - Expect 1024 we pulses with waddr=i and the matching wdata.
   - Expect done=1, ok=1, fmt_err=0, and exactly 6145 cycles from first byte to done.
2. Same stream, but the checksum byte is inverted.
   - Expect done=1, ok=0, fmt_err=0, and all 1024 writes still issued.
3. Entry 5 has 5th byte 0x1A (bit 4 set).
   - Expect fmt_err=1 and waddr=5 written with wdata[35:32]=4'hA.
   - Expect ok=0 even though the checksum is correct.
4. rx_valid toggles randomly, ~50% duty.
   - Expect the same writes as test 1, in order, with no duplicates.
   - Expect rx_ready=0 on every WRITE cycle.
5. Assert rstn=0 after entry 300 is written and mid-entry 301.
   - Expect all outputs 0 asynchronously and no further we.
   - Then start again: load restarts at waddr=0 and completes with ok=1.
6. Pulse start during BYTE at entry 10: expect it ignored, with address continuing at 10.
   - Pulse start in DONE: expect done, ok and fmt_err cleared next cycle and busy=1.
